rx_bit_decoder: RTL and testbench



---
 rtl/rx_bit_decoder.sv | 172 +++++++++++++++++
 tb/tb_rx_bit_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// rx_bit_decoder
//
// USB full-speed receive stage placed right after the RX bit-timing block.
// On each en_sample strobe it looks at the line state, NRZI-decodes J/K
// symbols, removes stuffed bits and assembles bits LSB-first into bytes.
// It also recognises the SE0 -> J end-of-packet sequence and illegal line
// states, and reports each of these with a one-cycle pulse.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   n_rst      - synchronous reset, active-high despite its name
//   d_plus     - USB D+ line, already synchronised
//   d_minus    - USB D- line, already synchronised
//   en_sample  - one-cycle mid-bit sample strobe
//   rx_data    - last completed byte, bit 0 is the first bit received
//   byte_ready - one-cycle pulse when rx_data has just been updated
//   eop        - one-cycle pulse on end of packet (SE0 followed by J)
//   align_err  - pulses together with eop when a partial byte was pending
//   stuff_err  - one-cycle pulse on a bit-stuffing violation
//   line_err   - one-cycle pulse on an illegal line state
// -----------------------------------------------------------------------------
module rx_bit_decoder #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       en_sample,
  output logic [7:0] rx_data,
  output logic       byte_ready,
  output logic       eop,
  output logic       align_err,
  output logic       stuff_err,
  output logic       line_err
);

  typedef enum logic {
    RECV     = 1'b0,
    SE0_SEEN = 1'b1
  } state_t;

  // Line states as {d_plus, d_minus}.
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

  // prev_line is kept as a single bit: 1 = J, 0 = K. After an SE0 or SE1
  // the reference for the next NRZI decision is always J.
  state_t     state_q,      state_d;
  logic       prev_line_q,  prev_line_d;
  logic [2:0] ones_cnt_q,   ones_cnt_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic [7:0] shift_q,      shift_d;
  logic [7:0] rx_data_q,    rx_data_d;
  logic       byte_ready_q, byte_ready_d;
  logic       eop_q,        eop_d;
  logic       align_err_q,  align_err_d;
  logic       stuff_err_q,  stuff_err_d;
  logic       line_err_q,   line_err_d;

  logic [1:0] line;
  logic       dec_bit;

  assign line    = {d_plus, d_minus};
  // NRZI: no transition means 1. For J/K samples d_plus alone identifies
  // the symbol, so it compares directly with the 1-bit prev_line.
  assign dec_bit = (d_plus == prev_line_q);

  // Next-state logic. Everything holds and all pulses are low unless a
  // sample strobe arrives; a stuffed bit is checked before byte completion
  // so it never advances bit_cnt.
  always_comb begin
    state_d      = state_q;
    prev_line_d  = prev_line_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    byte_ready_d = 1'b0;
    eop_d        = 1'b0;
    align_err_d  = 1'b0;
    stuff_err_d  = 1'b0;
    line_err_d   = 1'b0;

    if (en_sample) begin
      if (line == LINE_SE1) begin
        line_err_d  = 1'b1;
        bit_cnt_d   = 3'd0;
        ones_cnt_d  = 3'd0;
        prev_line_d = 1'b1;
        state_d     = RECV;
      end else if (line == LINE_SE0) begin
        if (state_q == RECV) begin
          state_d     = SE0_SEEN;
          prev_line_d = 1'b1;
        end
      end else if (state_q == SE0_SEEN) begin
        bit_cnt_d  = 3'd0;
        ones_cnt_d = 3'd0;
        state_d    = RECV;
        if (line == LINE_J) begin
          eop_d       = 1'b1;
          align_err_d = (bit_cnt_q != 3'd0);
        end else begin
          line_err_d  = 1'b1;
          prev_line_d = 1'b0;
        end
      end else begin
        prev_line_d = d_plus;
        if (ones_cnt_q == STUFF_MAX) begin
          // Expected stuffed 0; a 1 here breaks the stuffing rule and the
          // partial byte can no longer be trusted.
          ones_cnt_d = 3'd0;
          if (dec_bit) begin
            stuff_err_d = 1'b1;
            bit_cnt_d   = 3'd0;
          end
        end else begin
          shift_d    = {dec_bit, shift_q[7:1]};
          ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d    = {dec_bit, shift_q[7:1]};
            byte_ready_d = 1'b1;
          end
        end
      end
    end
  end

  // State register with synchronous reset; reset wins over en_sample.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= RECV;
      prev_line_q  <= 1'b1;
      ones_cnt_q   <= 3'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      byte_ready_q <= 1'b0;
      eop_q        <= 1'b0;
      align_err_q  <= 1'b0;
      stuff_err_q  <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_line_q  <= prev_line_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      byte_ready_q <= byte_ready_d;
      eop_q        <= eop_d;
      align_err_q  <= align_err_d;
      stuff_err_q  <= stuff_err_d;
      line_err_q   <= line_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign byte_ready = byte_ready_q;
  assign eop        = eop_q;
  assign align_err  = align_err_q;
  assign stuff_err  = stuff_err_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_rx_bit_decoder
//
// Directed bench for rx_bit_decoder. Line symbols are driven on strobe
// cycles and the registered outputs are sampled 1 time unit after the
// following clock edge. Pulses seen across a scenario are also counted so
// that "exactly once" and "never" properties can be checked.
// -----------------------------------------------------------------------------
module tb_rx_bit_decoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] SE1 = 2'b11;

  logic       clk;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic       en_sample;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       eop;
  logic       align_err;
  logic       stuff_err;
  logic       line_err;

  int checks;
  int errors;
  int br_cnt, eop_cnt, align_cnt, stuff_cnt, line_cnt;

  rx_bit_decoder #(.STUFF_LEN(6)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .en_sample  (en_sample),
    .rx_data    (rx_data),
    .byte_ready (byte_ready),
    .eop        (eop),
    .align_err  (align_err),
    .stuff_err  (stuff_err),
    .line_err   (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one symbol for exactly one strobe cycle, then sample the outputs
  // just after the edge that registers it.
  task automatic strobe(input logic [1:0] ln);
    @(negedge clk);
    {d_plus, d_minus} = ln;
    en_sample = 1'b1;
    @(posedge clk);
    #1;
    en_sample = 1'b0;
    br_cnt    += int'(byte_ready);
    eop_cnt   += int'(eop);
    align_cnt += int'(align_err);
    stuff_cnt += int'(stuff_err);
    line_cnt  += int'(line_err);
  endtask

  task automatic clear_counts();
    br_cnt = 0; eop_cnt = 0; align_cnt = 0; stuff_cnt = 0; line_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b1;
    en_sample = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    en_sample = 1'b0;
    {d_plus, d_minus} = J;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_byte_ready got %b exp 0", byte_ready); end
    checks++; if (eop !== 1'b0) begin errors++; $display("[TB] FAIL reset_eop got %b exp 0", eop); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_align_err got %b exp 0", align_err); end
    checks++; if (stuff_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_stuff_err got %b exp 0", stuff_err); end
    checks++; if (line_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_line_err got %b exp 0", line_err); end
    @(negedge clk);
    n_rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_byte_a5();
    logic [1:0] seq [8] = '{J, K, K, J, K, K, J, J};
    apply_reset();
    for (int i = 0; i < 7; i++) strobe(seq[i]);
    checks++; if (br_cnt !== 0) begin errors++; $display("[TB] FAIL a5_early_ready got %0d exp 0", br_cnt); end
    strobe(seq[7]);
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL a5_ready got %b exp 1", byte_ready); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data got %h exp a5", rx_data); end
    checks++; if ((eop_cnt + align_cnt + stuff_cnt + line_cnt) !== 0) begin errors++; $display("[TB] FAIL a5_no_errors got %0d exp 0", eop_cnt + align_cnt + stuff_cnt + line_cnt); end
    @(posedge clk);
    #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL a5_pulse_width got %b exp 0", byte_ready); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_hold got %h exp a5", rx_data); end
  endtask

  task automatic test_stuffed_zero();
    apply_reset();
    for (int i = 0; i < 6; i++) strobe(J);
    strobe(K);
    strobe(K);
    checks++; if (br_cnt !== 0) begin errors++; $display("[TB] FAIL stuff0_early_ready got %0d exp 0", br_cnt); end
    strobe(K);
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL stuff0_ready got %b exp 1", byte_ready); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("[TB] FAIL stuff0_data got %h exp ff", rx_data); end
    checks++; if (stuff_cnt !== 0) begin errors++; $display("[TB] FAIL stuff0_stuff_err got %0d exp 0", stuff_cnt); end
  endtask

  task automatic test_stuff_error();
    logic [1:0] seq [8] = '{J, K, K, J, K, K, J, J};
    apply_reset();
    for (int i = 0; i < 6; i++) strobe(J);
    checks++; if (stuff_cnt !== 0) begin errors++; $display("[TB] FAIL stufferr_early got %0d exp 0", stuff_cnt); end
    strobe(J);
    checks++; if (stuff_err !== 1'b1) begin errors++; $display("[TB] FAIL stufferr_pulse got %b exp 1", stuff_err); end
    clear_counts();
    for (int i = 0; i < 8; i++) strobe(seq[i]);
    checks++; if (byte_ready !== 1'b1 || br_cnt !== 1) begin errors++; $display("[TB] FAIL stufferr_recover_ready got %b/%0d exp 1/1", byte_ready, br_cnt); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL stufferr_recover_data got %h exp a5", rx_data); end
    checks++; if (stuff_cnt !== 0) begin errors++; $display("[TB] FAIL stufferr_recover_clean got %0d exp 0", stuff_cnt); end
  endtask

  task automatic test_eop();
    logic [1:0] seq [8] = '{J, K, K, J, K, K, J, J};
    apply_reset();
    for (int i = 0; i < 8; i++) strobe(seq[i]);
    clear_counts();
    strobe(SE0);
    strobe(SE0);
    checks++; if (eop_cnt !== 0) begin errors++; $display("[TB] FAIL eop_early got %0d exp 0", eop_cnt); end
    strobe(J);
    checks++; if (eop !== 1'b1) begin errors++; $display("[TB] FAIL eop_pulse got %b exp 1", eop); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("[TB] FAIL eop_align_clean got %b exp 0", align_err); end
    clear_counts();
    strobe(J);
    strobe(K);
    strobe(K);
    strobe(SE0);
    strobe(J);
    checks++; if (eop !== 1'b1 || align_err !== 1'b1) begin errors++; $display("[TB] FAIL eop_align_pulse got %b%b exp 11", eop, align_err); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL eop_rx_hold got %h exp a5", rx_data); end
    checks++; if (br_cnt !== 0 || line_cnt !== 0) begin errors++; $display("[TB] FAIL eop_spurious got %0d/%0d exp 0/0", br_cnt, line_cnt); end
  endtask

  task automatic test_line_errors();
    logic [1:0] seq_j [8] = '{J, K, K, J, K, K, J, J};
    logic [1:0] seq_k [8] = '{J, J, K, K, K, J, J, K};
    apply_reset();
    strobe(K);
    strobe(K);
    strobe(J);
    strobe(SE1);
    checks++; if (line_err !== 1'b1) begin errors++; $display("[TB] FAIL se1_line_err got %b exp 1", line_err); end
    clear_counts();
    for (int i = 0; i < 8; i++) strobe(seq_j[i]);
    checks++; if (byte_ready !== 1'b1 || br_cnt !== 1 || rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL se1_recover got %b/%0d/%h exp 1/1/a5", byte_ready, br_cnt, rx_data); end
    clear_counts();
    strobe(J);
    strobe(K);
    strobe(SE0);
    strobe(K);
    checks++; if (line_err !== 1'b1) begin errors++; $display("[TB] FAIL se0k_line_err got %b exp 1", line_err); end
    checks++; if (eop_cnt !== 0) begin errors++; $display("[TB] FAIL se0k_no_eop got %0d exp 0", eop_cnt); end
    clear_counts();
    for (int i = 0; i < 8; i++) strobe(seq_k[i]);
    checks++; if (byte_ready !== 1'b1 || br_cnt !== 1 || rx_data !== 8'h5A) begin errors++; $display("[TB] FAIL se0k_recover got %b/%0d/%h exp 1/1/5a", byte_ready, br_cnt, rx_data); end
  endtask

  task automatic test_reset_mid_byte();
    logic [1:0] seq [8] = '{J, K, K, J, K, K, J, J};
    clear_counts();
    for (int i = 0; i < 5; i++) strobe(seq[i]);
    @(negedge clk);
    n_rst = 1'b1;
    en_sample = 1'b1;
    {d_plus, d_minus} = J;
    @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rx_data got %h exp 00", rx_data); end
    checks++; if ({byte_ready, eop, align_err, stuff_err, line_err} !== 5'b0) begin errors++; $display("[TB] FAIL rstmid_pulses got %b exp 00000", {byte_ready, eop, align_err, stuff_err, line_err}); end
    @(negedge clk);
    n_rst = 1'b0;
    en_sample = 1'b0;
    clear_counts();
    for (int i = 0; i < 8; i++) strobe(seq[i]);
    checks++; if (byte_ready !== 1'b1 || br_cnt !== 1) begin errors++; $display("[TB] FAIL rstmid_ready got %b/%0d exp 1/1", byte_ready, br_cnt); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL rstmid_data got %h exp a5", rx_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_counts();
    n_rst = 1'b1;
    en_sample = 1'b0;
    {d_plus, d_minus} = J;
    test_reset();
    test_byte_a5();
    test_stuffed_zero();
    test_stuff_error();
    test_eop();
    test_line_errors();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
